// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer.
// Each raw active-low button line goes through a two-flop synchronizer.
// A per-channel counter then requires DEBOUNCE_CYCLES consecutive cycles
// of disagreement before the debounced level follows the input.
// A single cycle of agreement restarts the count.
// Press and release strobes are registered on the same edge as the level change.
module btn_debounce #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse
);

  // The largest count value is DEBOUNCE_CYCLES-1, so this width never overflows.
  localparam int              CW     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] w_level;

  // Two-flop synchronizer. It resets to all ones, which means released.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_level = ~r_sync2;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic          r_pressed;
    logic          r_press_pulse;
    logic          r_release_pulse;

    // Stability counter, debounced level, and edge strobes for one channel.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt           <= '0;
        r_pressed       <= 1'b0;
        r_press_pulse   <= 1'b0;
        r_release_pulse <= 1'b0;
      end else begin
        r_press_pulse   <= 1'b0;
        r_release_pulse <= 1'b0;
        if (w_level[i] == r_pressed) begin
          r_cnt <= '0;
        end else if (r_cnt != C_LAST) begin
          r_cnt <= r_cnt + CW'(1);
        end else begin
          r_cnt           <= '0;
          r_pressed       <= w_level[i];
          r_press_pulse   <= w_level[i];
          r_release_pulse <= ~w_level[i];
        end
      end
    end

    assign pressed[i]       = r_pressed;
    assign press_pulse[i]   = r_press_pulse;
    assign release_pulse[i] = r_release_pulse;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4 and N_BTN=2.
// Each step drives inputs on the falling edge and checks the outputs 1 ns
// after the following rising edge. With DEBOUNCE_CYCLES=4, the level
// changes on the 6th edge that samples the new input.
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn;
  logic [1:0] pressed;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;

  int checks   = 0;
  int failures = 0;

  btn_debounce #(.N_BTN(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] btn;
    logic [1:0] p;
    logic [1:0] pp;
    logic [1:0] rp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic r, input logic [1:0] b,
                     input logic [1:0] p, input logic [1:0] pp, input logic [1:0] rp);
    vec_t v;
    v.name = n; v.rst = r; v.btn = b; v.p = p; v.pp = pp; v.rp = rp;
    vecs.push_back(v);
  endtask

  // Drive inputs for one edge, then compare the outputs after that edge.
  task automatic step(input string n, input logic r, input logic [1:0] b,
                      input logic [1:0] p, input logic [1:0] pp, input logic [1:0] rp);
    @(negedge clk);
    rst = r;
    btn = b;
    @(posedge clk);
    #1;
    checks++;
    if (pressed !== p || press_pulse !== pp || release_pulse !== rp ||
        (press_pulse & release_pulse) !== 2'b00) begin
      failures++;
      $display("FAIL %s: got pressed=%b press_pulse=%b release_pulse=%b, need %b %b %b",
               n, pressed, press_pulse, release_pulse, p, pp, rp);
    end
  endtask

  initial begin
    rst = 1'b1;
    btn = 2'b11;

    // Reset holds the outputs at zero, even with both buttons held.
    add("reset_idle", 1, 2'b11, 2'b00, 2'b00, 2'b00);
    add("reset_btn_low", 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add("reset_btn_low2", 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add("idle", 0, 2'b11, 2'b00, 2'b00, 2'b00);
    // Clean press on channel 0.
    for (int k = 1; k <= 5; k++) add("press0_wait", 0, 2'b10, 2'b00, 2'b00, 2'b00);
    add("press0_edge6", 0, 2'b10, 2'b01, 2'b01, 2'b00);
    add("press0_hold", 0, 2'b10, 2'b01, 2'b00, 2'b00);
    add("press0_hold", 0, 2'b10, 2'b01, 2'b00, 2'b00);
    // Release on channel 0.
    for (int k = 1; k <= 5; k++) add("rel0_wait", 0, 2'b11, 2'b01, 2'b00, 2'b00);
    add("rel0_edge6", 0, 2'b11, 2'b00, 2'b00, 2'b01);
    add("rel0_after", 0, 2'b11, 2'b00, 2'b00, 2'b00);
    // A 3-cycle glitch on channel 1 is rejected.
    for (int k = 1; k <= 3; k++) add("glitch1_low", 0, 2'b01, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= 6; k++) add("glitch1_high", 0, 2'b11, 2'b00, 2'b00, 2'b00);
    // Simultaneous press and release on both channels.
    for (int k = 1; k <= 5; k++) add("both_wait", 0, 2'b00, 2'b00, 2'b00, 2'b00);
    add("both_edge6", 0, 2'b00, 2'b11, 2'b11, 2'b00);
    add("both_hold", 0, 2'b00, 2'b11, 2'b00, 2'b00);
    for (int k = 1; k <= 5; k++) add("both_rel_wait", 0, 2'b11, 2'b11, 2'b00, 2'b00);
    add("both_rel_edge6", 0, 2'b11, 2'b00, 2'b00, 2'b11);
    add("both_rel_after", 0, 2'b11, 2'b00, 2'b00, 2'b00);

    foreach (vecs[i])
      step(vecs[i].name, vecs[i].rst, vecs[i].btn, vecs[i].p, vecs[i].pp, vecs[i].rp);

    // Bounce on channel 0: 0,1,0,1, then hold 0. The press must land 6 edges
    // after the final 1->0 transition, with no earlier strobe.
    step("bounce_0", 0, 2'b10, 2'b00, 2'b00, 2'b00);
    step("bounce_1", 0, 2'b11, 2'b00, 2'b00, 2'b00);
    step("bounce_2", 0, 2'b10, 2'b00, 2'b00, 2'b00);
    step("bounce_3", 0, 2'b11, 2'b00, 2'b00, 2'b00);
    for (int j = 1; j <= 8; j++) begin
      if (j < 6)       step("bounce_wait", 0, 2'b10, 2'b00, 2'b00, 2'b00);
      else if (j == 6) step("bounce_edge6", 0, 2'b10, 2'b01, 2'b01, 2'b00);
      else             step("bounce_hold", 0, 2'b10, 2'b01, 2'b00, 2'b00);
    end
    for (int j = 1; j <= 7; j++) begin
      if (j < 6)       step("bounce_rel_wait", 0, 2'b11, 2'b01, 2'b00, 2'b00);
      else if (j == 6) step("bounce_rel_edge6", 0, 2'b11, 2'b00, 2'b00, 2'b01);
      else             step("bounce_rel_after", 0, 2'b11, 2'b00, 2'b00, 2'b00);
    end

    // Reset mid-count: btn[0] low, rst on edge 4. The count restarts,
    // and the press fires on the 6th edge after rst falls.
    for (int j = 1; j <= 3; j++) step("rstmid_count", 0, 2'b10, 2'b00, 2'b00, 2'b00);
    step("rstmid_rst", 1, 2'b10, 2'b00, 2'b00, 2'b00);
    for (int j = 1; j <= 7; j++) begin
      if (j < 6)       step("rstmid_wait", 0, 2'b10, 2'b00, 2'b00, 2'b00);
      else if (j == 6) step("rstmid_edge6", 0, 2'b10, 2'b01, 2'b01, 2'b00);
      else             step("rstmid_hold", 0, 2'b10, 2'b01, 2'b00, 2'b00);
    end

    // Reset while pressed clears the level and produces no release strobe.
    step("rst_pressed", 1, 2'b10, 2'b00, 2'b00, 2'b00);
    step("rst_pressed2", 1, 2'b11, 2'b00, 2'b00, 2'b00);
    step("post_rst_idle", 0, 2'b11, 2'b00, 2'b00, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter N_BTN, default 2, giving the number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 270000 (10 ms at 27 MHz), giving the stable-input cycles needed before a state change; legal range 2..2^24.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port btn, input, N_BTN bits: raw, asynchronous, bouncing button lines, active-low (0 = pressed).
REQ-006 SHALL have port pressed, output, N_BTN bits: debounced level, active-high (1 = pressed); this directly drives the downstream latch clock and data inputs.
REQ-007 SHALL have port press_pulse, output, N_BTN bits: one-cycle strobe on a debounced press.
REQ-008 SHALL have port release_pulse, output, N_BTN bits: one-cycle strobe on a debounced release.

Function
REQ-009 SHALL pass each btn bit through a two-flop synchronizer before any other use; no other logic reads btn directly.
REQ-010 SHALL give each channel its own stable-state register, counter, and pulse registers; channels do not interact.
REQ-011 SHALL size the counter as $clog2(DEBOUNCE_CYCLES) bits, with no overflow possible.
REQ-012 SHALL, each cycle, compare synchronized level s (inverted to active-high) against pressed[i]:
- if equal, clear the counter;
- if different and counter < DEBOUNCE_CYCLES-1, increment the counter;
- if different and counter == DEBOUNCE_CYCLES-1, load pressed[i] <= s and clear the counter.
REQ-013 SHALL restart the count from zero on any bounce: a single cycle of s equal to pressed[i] clears the counter.
REQ-014 SHALL make every output a registered output, with no combinational path from btn to any output.
REQ-015 SHALL assert press_pulse[i] for exactly one cycle, coinciding with the first cycle pressed[i] is 1.
REQ-016 SHALL assert release_pulse[i] for exactly one cycle, coinciding with the first cycle pressed[i] is 0.
REQ-017 SHALL never assert press_pulse[i] and release_pulse[i] together.
REQ-018 SHALL give a latency of exactly DEBOUNCE_CYCLES+2 rising edges from a clean btn transition to the pressed change; edge 1 is the first edge that samples the new level.
REQ-019 SHALL ignore any pulse or glitch shorter than DEBOUNCE_CYCLES cycles after synchronization; pressed does not change.
REQ-020 SHALL let channels transition on the same edge without interference when their buttons change simultaneously.

Reset
REQ-021 SHALL, while rst=1 at a clock edge, set:
- synchronizer flops to 1 (released);
- pressed to 0;
- counters to 0;
- press_pulse and release_pulse to 0.
REQ-022 SHALL, on rst asserted mid-count, discard the count and produce no pulse for that cycle or after it.
REQ-023 SHALL, if a button is held through reset deassertion, report the press normally: press_pulse fires DEBOUNCE_CYCLES+2 edges after the first edge with rst=0.
REQ-024 SHALL hold outputs at reset values during reset regardless of btn.

Verification (DEBOUNCE_CYCLES=4, N_BTN=2)
REQ-025 SHALL cover clean press: btn[0] 1->0 and held -> pressed[0] rises at edge 6; press_pulse[0]=1 for that cycle only; channel 1 outputs stay 0.
REQ-026 SHALL cover bounce: btn[0] toggles 0,1,0,1 each cycle, then holds 0 -> pressed[0] rises exactly 6 edges after the final 1->0; there are no intermediate pulses.
REQ-027 SHALL cover glitch rejection: btn[1] low for 3 cycles, then high -> pressed[1] stays 0 and no pulses appear.
REQ-028 SHALL cover release: from pressed[0]=1, btn[0] 0->1 -> pressed[0] falls at edge 6; release_pulse[0]=1 for one cycle.
REQ-029 SHALL cover simultaneous press: btn=2'b11->2'b00 on the same edge -> pressed=2'b11 and press_pulse=2'b11 on the same edge 6.
REQ-030 SHALL cover reset mid-count: btn[0] low, rst=1 at edge 4 for one cycle -> all outputs 0, no pulse; press_pulse[0] fires 6 edges after rst falls.
